apb_rm_arbiter: RTL
===================

# apb_rm_arbiter

Two-port APB master arbiter for the register map. It shares the register-map APB slave port between the SPI slave bridge (port 0) and the on-chip crypto engine (port 1), so both can read and write the 20-bit address / 16-bit data register space. It has a per-requester valid/ready request channel and a one-cycle response pulse. It issues one APB transfer at a time, grants round-robin, and aborts a transfer with an error if `pready` never arrives.

## Interface
- `ADDR_W`, 20, APB/request address width
- `DATA_W`, 16, APB/request data width
- `TIMEOUT`, 255, maximum ACCESS cycles waiting for `pready` before abort (≥1)
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `sN_valid` in 1 (N=0,1): request pending; held with fields stable until `sN_ready`
- `sN_write` in 1: 1 = write, 0 = read
- `sN_addr` in ADDR_W: target address
- `sN_wdata` in DATA_W: write data (ignored on read)
- `sN_ready` out 1: one-cycle accept pulse
- `sN_rvalid` out 1: one-cycle completion pulse
- `sN_rdata` out DATA_W: read data, valid with `sN_rvalid`
- `sN_err` out 1: `pslverr` or timeout, valid with `sN_rvalid`
- `psel`, `penable`, `pwrite` out 1: APB control
- `paddr` out ADDR_W; `pwdata` out DATA_W
- `prdata` in DATA_W; `pready` in 1; `pslverr` in 1
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE → SETUP → ACCESS → IDLE.
- IDLE, no valid: stay.
- IDLE, any `sN_valid`: grant a requester, latch its write/addr/wdata, go to SETUP.
- SETUP: `psel`=1, `penable`=0, `sN_ready`=1 for the granted N. Always goes to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - With `pready`=1: capture `prdata`/`pslverr`, go to IDLE.
  - Otherwise, increment the wait counter. When the counter reaches TIMEOUT, abort to IDLE with err=1.
- Response: in the first IDLE cycle after ACCESS, the granted port gets `sN_rvalid`=1.
  - `sN_err` = `pslverr` or timeout.
  - `sN_rdata` = captured `prdata` only for a read with err=0; otherwise 0.
- Arbitration: a `last_grant` pointer, reset value 1, so port 0 wins first after reset.
  - Both valid: grant the port ≠ `last_grant`.
  - Single valid: grant that port.
  - `last_grant` updates on each grant.
- `pwdata` = latched wdata on a write, 0 on a read. `paddr`/`pwrite` are held from SETUP through ACCESS and are 0 in IDLE.
- The requester must deassert valid the cycle after `sN_ready`. If valid is still high in the response cycle, that is treated as a new request.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=1, counter 0.
- Asynchronous reset mid-transfer: APB outputs drop immediately, the transfer is lost, and no `rvalid` is issued.
- All outputs are registered.
- Cycle sequence:
  - cycle 0: IDLE sees valid.
  - cycle 1: SETUP, `ready` pulse.
  - cycle 2: ACCESS.
  - cycle 2+W: the `pready` cycle, after W wait states.
  - cycle 3+W: `rvalid` pulse, IDLE.
- Back-to-back: a request seen in the response cycle enters SETUP next cycle, giving a 3-cycle minimum period per transfer.
- Timeout: `pready` never arrives, so ACCESS lasts exactly TIMEOUT cycles; then `psel`/`penable`=0 and `rvalid`/`err`=1.
- `pready` on the same cycle the counter reaches TIMEOUT: the transfer completes normally and `pready` takes precedence.

## Structure
- Package `rm_arb_pkg`:
  - state enum (IDLE/SETUP/ACCESS)
  - default `ADDR_W`/`DATA_W`/`TIMEOUT`
  - port index constants `PORT_SPI`=0, `PORT_CRYPTO`=1
- Sub-module `rr_arbiter2`: two-input round-robin grant plus `last_grant` pointer. Inputs: valid[1:0] and an update enable. Output: one-hot grant.

## Test plan
1. Port 0 write, addr 20'h5AD01, data 16'hCCDF, `pready`=1 at once. Expect:
   - `s0_ready` at cycle 1
   - `psel`=1 at cycles 1–2, `penable` at cycle 2
   - `paddr`=5AD01, `pwdata`=CCDF, `pwrite`=1
   - `s0_rvalid`=1 with err=0 at cycle 3
2. Port 1 read of 20'h5AD01, slave returns 16'hCCDF after 3 wait states. Expect `s1_rvalid` at cycle 6, `s1_rdata`=CCDF, err=0, `pwdata`=0.
3. Both ports valid continuously after reset, each re-raising valid after its response. Expect grant order 0,1,0,1 over 4 transfers, and never two grants to one port while the other is valid.
4. TIMEOUT=8, `pready` held 0. Expect ACCESS for exactly 8 cycles, then `psel`=0 and `rvalid`=1 with err=1, rdata=16'h0000, `busy`=0.
5. Read with `pslverr`=1 and `prdata`=16'hBEEF. Expect rvalid with err=1 and rdata=16'h0000.
6. `rst_n` pulsed low during ACCESS. Expect `psel`/`penable` to go 0 without waiting for a clock edge and no `rvalid`. After release, with `s0` and `s1` both valid, expect `s0` granted first.

Source files
------------

// File: rtl/rm_arb_pkg.sv
//------------------------------------------------------------------------------
// Module : rm_arb_pkg
// Brief  : Shared types and defaults for the register-map APB arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int RM_ADDR_W  = 20;
  localparam int RM_DATA_W  = 16;
  localparam int RM_TIMEOUT = 255;

  localparam logic PORT_SPI    = 1'b0;
  localparam logic PORT_CRYPTO = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter2
// Brief  : Two-input round-robin grant with a last-grant pointer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import rm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  logic r_last_grant;

  // Contention goes to the port that was not served last.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (r_last_grant == PORT_SPI) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_CRYPTO;
    end else if (update && (grant != 2'b00)) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_rm_arbiter.sv
//------------------------------------------------------------------------------
// Module : apb_rm_arbiter
// Brief  : Two-port APB master arbiter (SPI bridge / crypto) with timeout.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_rm_arbiter
  import rm_arb_pkg::*;
#(
  parameter int ADDR_W  = RM_ADDR_W,
  parameter int DATA_W  = RM_DATA_W,
  parameter int TIMEOUT = RM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic              s0_write,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  output logic              s0_ready,
  output logic              s0_rvalid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_err,
  input  logic              s1_valid,
  input  logic              s1_write,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  output logic              s1_ready,
  output logic              s1_rvalid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_port;
  logic [CNT_W-1:0]  r_wait;
  logic [CNT_W-1:0]  w_wait_next;

  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_grant_en;
  logic              w_gnt_port;
  logic              w_req_write;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_timeout;
  logic              w_done;

  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic [1:0]        r_ready, w_ready;
  logic [1:0]        r_rvalid, w_rvalid;
  logic [1:0]        r_err, w_err;
  logic [DATA_W-1:0] r_rdata [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic              r_busy;

  assign w_valid    = {s1_valid, s0_valid};
  assign w_grant_en = (r_state == IDLE) && (w_valid != 2'b00);
  assign w_gnt_port = w_grant[1];

  assign w_req_write = w_gnt_port ? s1_write : s0_write;
  assign w_req_addr  = w_gnt_port ? s1_addr  : s0_addr;
  assign w_req_wdata = w_gnt_port ? s1_wdata : s0_wdata;

  // The TIMEOUT-th ACCESS cycle without pready aborts; pready still wins there.
  assign w_timeout = (r_wait == CNT_W'(TIMEOUT - 1));
  assign w_done    = (r_state == ACCESS) && (pready || w_timeout);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (w_valid),
    .update (w_grant_en),
    .grant  (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_en) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of every registered output, so all ports come straight off flops.
  always_comb begin
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_pwrite    = 1'b0;
    w_paddr     = '0;
    w_pwdata    = '0;
    w_ready     = 2'b00;
    w_rvalid    = 2'b00;
    w_err       = 2'b00;
    w_rdata[0]  = '0;
    w_rdata[1]  = '0;
    w_wait_next = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_en) begin
          w_psel              = 1'b1;
          w_ready[w_gnt_port] = 1'b1;
          w_pwrite            = w_req_write;
          w_paddr             = w_req_addr;
          w_pwdata            = w_req_write ? w_req_wdata : '0;
        end
      end
      SETUP: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        w_pwrite  = r_pwrite;
        w_paddr   = r_paddr;
        w_pwdata  = r_pwdata;
      end
      ACCESS: begin
        if (w_done) begin
          w_rvalid[r_port] = 1'b1;
          w_err[r_port]    = !pready || pslverr;
          w_rdata[r_port]  = (pready && !pslverr && !r_pwrite) ? prdata : '0;
        end else begin
          w_psel      = 1'b1;
          w_penable   = 1'b1;
          w_pwrite    = r_pwrite;
          w_paddr     = r_paddr;
          w_pwdata    = r_pwdata;
          w_wait_next = r_wait + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port     <= PORT_SPI;
      r_wait     <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_ready    <= 2'b00;
      r_rvalid   <= 2'b00;
      r_err      <= 2'b00;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_grant_en) begin
        r_port <= w_gnt_port;
      end
      r_wait     <= w_wait_next;
      r_psel     <= w_psel;
      r_penable  <= w_penable;
      r_pwrite   <= w_pwrite;
      r_paddr    <= w_paddr;
      r_pwdata   <= w_pwdata;
      r_ready    <= w_ready;
      r_rvalid   <= w_rvalid;
      r_err      <= w_err;
      r_rdata[0] <= w_rdata[0];
      r_rdata[1] <= w_rdata[1];
      r_busy     <= (w_state_next != IDLE);
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign s0_ready  = r_ready[0];
  assign s1_ready  = r_ready[1];
  assign s0_rvalid = r_rvalid[0];
  assign s1_rvalid = r_rvalid[1];
  assign s0_err    = r_err[0];
  assign s1_err    = r_err[1];
  assign s0_rdata  = r_rdata[0];
  assign s1_rdata  = r_rdata[1];
  assign busy      = r_busy;

endmodule

`default_nettype wire
